// File: rtl/led_fade.sv
// led_fade: PWM fade-out stage behind the LED chaser.
// A lit pattern bit drives its LED full-on. A cleared bit lets the LED decay
// in fixed steps, which leaves a trailing "comet" tail behind the chaser.
// All channels share one PWM counter and one decay prescaler.

// Per-channel brightness level, period-aligned duty shadow and PWM compare.
module led_fade_lane #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_on,
  input  logic                i_period_end,
  input  logic                i_decay_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] duty;

  // Brightness: re-light beats decay, and decay saturates at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)             level <= '0;
    else if (i_on)         level <= MAX;
    else if (i_decay_tick) level <= (level > STEP) ? level - STEP : '0;
  end

  // Duty only changes on the edge where the PWM counter wraps, so no runt pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)             duty <= '0;
    else if (i_period_end) duty <= level;
  end

  // Registered PWM compare; MAX is forced fully on rather than MAX/(MAX+1).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_led <= 1'b0;
    else       o_led <= (duty == MAX) || (i_pwm_cnt < duty);
  end
endmodule

// Top: shared PWM counter and decay prescaler, plus one lane per LED.
module led_fade #(
  parameter int N_LEDS     = 4,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 16,
  parameter int DECAY_STEP = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_LEDS-1:0] i_pattern,
  output logic [N_LEDS-1:0] o_led
);
  localparam int                  DW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       dcnt;
  logic                period_end;
  logic                decay_tick;

  assign period_end = (pwm_cnt == MAX);
  assign decay_tick = period_end && (dcnt == DLAST);

  // Free-running PWM counter; natural wrap at MAX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Decay prescaler counts PWM periods, wrapping at DECAY_DIV-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           dcnt <= '0;
    else if (period_end) dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
  end

  for (genvar k = 0; k < N_LEDS; k++) begin : g_lane
    led_fade_lane #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_lane (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_on        (i_pattern[k]),
      .i_period_end(period_end),
      .i_decay_tick(decay_tick),
      .i_pwm_cnt   (pwm_cnt),
      .o_led       (o_led[k])
    );
  end
endmodule
